// File: rtl/radix9_serial_accumulator_pkg.sv
// radix9_pkg: shared radix-9 constants and the accumulator FSM state encoding.
package radix9_pkg;
    localparam int RADIX = 9;
    localparam int DIGIT_W = 4;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
endpackage

// File: rtl/radix9_serial_accumulator_if.sv
// radix9_serial_accumulator_if: request/status bundle between a requester and the accumulator.
interface radix9_serial_accumulator_if #(parameter int NDIG = 4);
    import radix9_pkg::*;
    logic start;
    logic clear;
    logic [DIGIT_W*NDIG-1:0] opIn;
    logic [DIGIT_W*NDIG-1:0] acc;
    logic busy;
    logic done;
    logic ovf;
    logic err;
    modport master (output start, clear, opIn, input acc, busy, done, ovf, err);
    modport slave (input start, clear, opIn, output acc, busy, done, ovf, err);
endinterface

// File: rtl/radix9_serial_accumulator_digit_add.sv
// radix9_digit_add: one radix-9 digit step, a + b + cin folded back into 0..8 with carry-out.
module radix9_digit_add
    import radix9_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout
);
    logic [DIGIT_W:0] s;
    always_comb begin
        s = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        cout = s >= (DIGIT_W+1)'(RADIX);
        sum = cout ? DIGIT_W'(s - (DIGIT_W+1)'(RADIX)) : s[DIGIT_W-1:0];
    end
endmodule

// File: rtl/radix9_serial_accumulator.sv
// radix9_serial_accumulator: digit-serial radix-9 accumulator, one digit per clock, LSD first.
module radix9_serial_accumulator
    import radix9_pkg::*;
#(
    parameter int NDIG = 4
) (
    input logic clk,
    input logic rst,
    radix9_serial_accumulator_if.slave bus
);
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
    state_t state;
    logic [DIGIT_W*NDIG-1:0] acc_q;
    logic [DIGIT_W*NDIG-1:0] op_q;
    logic [IW-1:0] idx;
    logic carry;
    logic ovf_q;
    logic err_q;
    logic done_q;
    logic busy_q;
    logic bad;
    logic [DIGIT_W-1:0] dsum;
    logic dcout;
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++)
            bad = bad | (bus.opIn[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(RADIX - 1));
    end
    // A single digit adder is shared across all positions, steered by idx.
    radix9_digit_add u_add (
        .a(acc_q[idx*DIGIT_W +: DIGIT_W]),
        .b(op_q[idx*DIGIT_W +: DIGIT_W]),
        .cin(carry),
        .sum(dsum),
        .cout(dcout)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc_q <= '0;
            op_q <= '0;
            idx <= '0;
            carry <= 1'b0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else if (bus.clear) begin
            state <= IDLE;
            acc_q <= '0;
            idx <= '0;
            carry <= 1'b0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    op_q <= bus.opIn;
                    idx <= '0;
                    carry <= 1'b0;
                    busy_q <= 1'b1;
                    err_q <= err_q | bad;
                    done_q <= bad;
                    state <= bad ? DONE : ADD;
                end
                ADD: begin
                    acc_q[idx*DIGIT_W +: DIGIT_W] <= dsum;
                    carry <= dcout;
                    if (idx == IW'(NDIG - 1)) begin
                        ovf_q <= ovf_q | dcout;
                        done_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.acc = acc_q;
    assign bus.ovf = ovf_q;
    assign bus.err = err_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
endmodule

// File: doc/radix9_serial_accumulator.md
RADIX9_SERIAL_ACCUMULATOR -- requirements
Module: radix9_serial_accumulator

Interface
REQ-001 Parameter NDIG, default 4, is the number of radix-9 digits in the operand and in the accumulator.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to add opIn into the accumulator; sampled only in IDLE.
REQ-005 clear  input  1  synchronous clear of the accumulator and all flags.
REQ-006 opIn  input  4*NDIG  operand, 4-bit digits, digit 0 in bits [3:0] (LSD).
REQ-007 acc  output  4*NDIG  accumulator value, same digit layout as opIn.
REQ-008 busy  output  1  high while an operation is in progress (ADD or DONE).
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 ovf  output  1  sticky carry-out of the most significant digit.
REQ-011 err  output  1  sticky flag for an illegal operand digit.

Function
REQ-012 The FSM SHALL have the states IDLE, ADD and DONE.
REQ-013 In IDLE with start=1 and clear=0, the block SHALL latch opIn, clear the carry and the digit index, and enter ADD on that edge.
REQ-014 If any latched digit is >8, the block SHALL set err, leave acc unchanged, and go from IDLE directly to DONE.
REQ-015 In ADD, each edge SHALL process one digit, index 0..NDIG-1, LSD first:
- s = acc[i] + op[i] + carry;
- if s>=9: acc[i] = s-9 and carry = 1; otherwise acc[i] = s and carry = 0.
REQ-016 The edge that processes digit NDIG-1 SHALL set ovf if the final carry is 1, leave acc as the sum modulo 9^NDIG, and enter DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1 and busy=1, then return to IDLE.
REQ-018 Latency: if start is sampled at edge T, done SHALL be high in the cycle following edge T+NDIG (invalid operand: the cycle following edge T).
REQ-019 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-020 clear=1 in any state SHALL, on that edge, set acc, ovf, err, carry and index to 0 and the state to IDLE.
- clear SHALL have priority over start.
- clear SHALL abort an ADD in progress without a done pulse.
REQ-021 Partially updated acc digits MAY be visible during ADD.
- Every acc digit SHALL remain in the range 0..8 at all times.
REQ-022 ovf and err SHALL persist across later operations until clear or rst.
REQ-023 busy SHALL be 0 in IDLE and 1 in ADD and DONE; done SHALL be 0 outside DONE.

Reset
REQ-024 rst=1 SHALL, on the edge, force:
- state IDLE;
- acc, the operand register, carry, index, ovf and err all to 0;
- done and busy to 0 in the following cycle.
REQ-025 rst SHALL override clear and start, including a reset in the middle of ADD.

Structure
REQ-026 The shared package radix9_pkg SHALL hold:
- RADIX=9;
- DIGIT_W=4;
- the FSM state enumeration (IDLE, ADD, DONE).
REQ-027 A combinational sub-module radix9_digit_add (two digits plus carry-in, giving a digit plus carry-out) SHALL perform the per-digit step and be instantiated once.
- It SHALL be multiplexed by the digit index.

Verification (NDIG=4, values as hex digit fields)
REQ-028 Reset, then start with opIn=0008 -> acc=0008, ovf=0, and done high for one cycle, in the cycle following the 4th edge after the start edge.
REQ-029 With acc=0008, start with opIn=0001 -> acc=0010, ovf=0.
REQ-030 With acc=8888, start with opIn=0001 -> acc=0000, ovf=1; a subsequent add of 0001 gives acc=0001 with ovf still 1.
REQ-031 With acc=0012, start with opIn=0009 -> err=1, acc=0012, and done in the cycle following the start edge.
REQ-032 start during ADD is ignored; start and clear together in IDLE with acc=0345 -> acc=0000, busy stays 0, no done.
REQ-033 rst asserted on the second ADD cycle -> the next cycle shows acc=0000, busy=0, done=0, ovf=0, err=0.
